regfile_wb_arbiter: RTL
=======================

# regfile_wb_arbiter

Round-robin arbiter that shares the register file's single write port (we3/wa3/wd3) among NREQ writeback requesters (ALU, load unit, multiplier, ...). Each requester offers an address/data pair on a valid/ready handshake; the arbiter grants one per cycle, registers the winner, and drives the regfile write port for exactly one cycle. It sits between the execute/writeback stages and regfile, and owns all writes to it.

## Interface
- NREQ, 4: number of requesters (2..8)
- n, 32: data width, matches regfile
- r, 5: address width, matches regfile
- clk  in  1  rising-edge clock, shared with regfile
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  when 1, no new grants (pending write still drains)
- req_valid  in  NREQ  requester i has a write pending
- req_addr  in  NREQ×r  destination register per requester
- req_data  in  NREQ×n  write data per requester
- req_ready  out  NREQ  one-hot grant; transfer when valid&ready
- we3  out  1  regfile write enable (registered)
- wa3  out  r  regfile write address (registered)
- wd3  out  n  regfile write data (registered)
- grant_id  out  clog2(NREQ)  index of requester driving current we3 cycle
- byp_ra1, byp_ra2  in  r  read addresses presented to regfile (used only with forwarding)
- byp_hit1, byp_hit2  out  1  staged write matches read address (forwarding only)
- byp_wd  out  n  forwarded data, equals wd3 (forwarding only)

## Operation
- Winner: first requester with req_valid=1 searching upward from rr_ptr, wrapping NREQ-1→0.
- req_ready is combinational, one-hot, asserted only for the winner and only when hold=0 and rst_n=1; zero when no valid.
- On a transfer at edge k: wa3/wd3 capture winner's addr/data, grant_id captures index, rr_ptr ← (winner+1) mod NREQ.
- we3 = 1 after a transfer, except req_addr=0: transfer accepted (ready=1), but we3 stays 0 (register 0 never written); rr_ptr still advances.
- No transfer at edge k → we3=0 in cycle k+1; wa3/wd3/grant_id hold previous values.
- rr_ptr does not move when no transfer occurs (including hold=1).
- Requester must hold valid/addr/data stable until ready; arbiter never drops a valid request, so starvation bound is NREQ-1 grants.
- Two requesters targeting the same address in consecutive cycles: writes land in grant order; later one wins.
- States: IDLE (we3=0) and WRITE (we3=1); IDLE→WRITE on non-zero-address transfer, WRITE→WRITE on another, WRITE→IDLE otherwise.

## Timing
- Reset (async, rst_n=0): we3=0, wa3=0, wd3=0, grant_id=0, rr_ptr=0, state IDLE, req_ready=0, byp_hit*=0.
- Latency: request accepted at edge k → we3 high during cycle k+1 → regfile stores at edge k+1; value readable on rd1/rd2 from cycle k+2.
- Throughput: one write per cycle, back-to-back.
- Reset asserted mid-write: we3 drops immediately; that write is lost; requesters must re-present after rst_n release.
- hold rising while we3=1: current write completes; no new grant.

## Configuration
- REGFILE_WB_FWD_EN defined: byp_hit1 = we3 & (wa3==byp_ra1) & (byp_ra1≠0), byp_hit2 likewise for byp_ra2; byp_wd = wd3. Combinational, lets readers see the value in cycle k+1 before the regfile stores it.
- Undefined: byp_hit1=byp_hit2=0, byp_wd=0 constantly; byp_ra* ignored; no comparators synthesized.

## Structure
- Shared package regfile_pkg: REG_N=32, REG_R=5, REG_ZERO address constant, wb_state_t enum {IDLE, WRITE}.
- Sub-module rr_picker: parameter NREQ; inputs valid vector and rr_ptr; outputs one-hot grant, index, any_valid. Purely combinational, reused by future read-port arbiters.

## Test plan
- Reset: rst_n=0 with all valids high → we3=0, wa3=0, req_ready=0; after release, rr_ptr=0, requester 0 granted first.
- Single write: req 1 valid, addr 5, data 0xA5A5 → ready[1] at edge k, we3=1/wa3=5/wd3=0xA5A5/grant_id=1 in cycle k+1, regfile reads 0xA5A5 at addr 5 from cycle k+2.
- Round-robin: all 4 valid continuously with distinct addrs → grant order 0,1,2,3,0; we3 high every cycle; no requester waits >3 grants.
- Zero address: req 2 writes addr 0 data 0x1234 → ready[2]=1, we3 stays 0, reg 0 still reads 0, next grant starts from 3.
- Hold: hold=1 for 3 cycles with req 0 valid → ready=0, we3=0 after drain, rr_ptr unchanged; release → req 0 granted next edge.
- Forwarding (REGFILE_WB_FWD_EN): write addr 3 data 0x1234, byp_ra1=3 → byp_hit1=1, byp_wd=0x1234 in cycle k+1; byp_ra1=0 with wa3=0 never hits; without macro byp_hit1=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path.
package regfile_pkg;

   localparam int unsigned REG_N = 32;
   localparam int unsigned REG_R = 5;

   // Register 0 is hard-wired to zero and never written.
   localparam logic [REG_R-1:0] REG_ZERO = '0;

   typedef enum logic {IDLE, WRITE} wb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first valid requester searching upward from rr_ptr, wrapping to 0.
// Purely combinational so it can be shared with other port arbiters.
module rr_picker #(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0]         valid,
   input  logic [$clog2(NREQ)-1:0] rr_ptr,
   output logic [NREQ-1:0]         grant,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    any_valid
);

   localparam int unsigned IDW = $clog2(NREQ);

   // Scan NREQ slots starting at rr_ptr; the first valid one wins.
   always_comb begin
      grant     = '0;
      idx       = '0;
      any_valid = 1'b0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         if (!any_valid && valid[(32'(rr_ptr) + off) % NREQ]) begin
            grant[(32'(rr_ptr) + off) % NREQ] = 1'b1;
            idx       = IDW'((32'(rr_ptr) + off) % NREQ);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter owning the register file's single write port (we3/wa3/wd3).
// Optional write forwarding to the read ports is enabled by defining REGFILE_WB_FWD_EN.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned n    = REG_N,
   parameter int unsigned r    = REG_R
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     hold,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0][r-1:0]   req_addr,
   input  logic [NREQ-1:0][n-1:0]   req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     we3,
   output logic [r-1:0]             wa3,
   output logic [n-1:0]             wd3,
   output logic [$clog2(NREQ)-1:0]  grant_id,
   input  logic [r-1:0]             byp_ra1,
   input  logic [r-1:0]             byp_ra2,
   output logic                     byp_hit1,
   output logic                     byp_hit2,
   output logic [n-1:0]             byp_wd
);

   localparam int unsigned IDW = $clog2(NREQ);

   wb_state_t        state;
   logic [IDW-1:0]   rr_ptr;
   logic [NREQ-1:0]  win_grant;
   logic [IDW-1:0]   win_idx;
   logic             any_valid;
   logic             xfer;
   logic [r-1:0]     win_addr;
   logic [n-1:0]     win_data;

   rr_picker #(
      .NREQ (NREQ)
   ) u_picker (
      .valid     (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (win_grant),
      .idx       (win_idx),
      .any_valid (any_valid)
   );

   assign xfer     = any_valid && !hold && rst_n;
   assign win_addr = req_addr[win_idx];
   assign win_data = req_data[win_idx];

   // Grant is combinational and suppressed during hold and reset.
   always_comb begin
      req_ready = '0;
      if (!hold && rst_n) req_ready = win_grant;
   end

   // Write-port FSM: capture the winner, advance the pointer, and write for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wa3      <= '0;
         wd3      <= '0;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else if (xfer) begin
         wa3      <= win_addr;
         wd3      <= win_data;
         grant_id <= win_idx;
         rr_ptr   <= (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
         // A write to register 0 is accepted but never reaches the regfile.
         state    <= (win_addr != r'(REG_ZERO)) ? WRITE : IDLE;
      end else begin
         state    <= IDLE;
      end
   end

   assign we3 = (state == WRITE);

`ifdef REGFILE_WB_FWD_EN
   // Expose the staged write to readers one cycle before the regfile stores it.
   assign byp_hit1 = we3 && (wa3 == byp_ra1) && (byp_ra1 != r'(REG_ZERO));
   assign byp_hit2 = we3 && (wa3 == byp_ra2) && (byp_ra2 != r'(REG_ZERO));
   assign byp_wd   = wd3;
`else
   logic unused_byp;
   assign unused_byp = ^{byp_ra1, byp_ra2};
   assign byp_hit1   = 1'b0;
   assign byp_hit2   = 1'b0;
   assign byp_wd     = '0;
`endif

endmodule
